// File: rtl/alu_pipelined.sv
// Handshaked ALU: single-cycle ops return on the next edge, MUL runs a WIDTH-cycle shift-add loop.
// Result and flags are held in registers until the consumer takes them.
module alu_pipelined #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             InValid,
    output logic             InReady,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       ALUControl,
    output logic             OutValid,
    input  logic             OutReady,
    output logic [WIDTH-1:0] ALUResult,
    output logic             Carry,
    output logic             Zero,
    output logic             Negative,
    output logic             Overflow
);

    localparam logic [3:0] OpAdd = 4'd0;
    localparam logic [3:0] OpSub = 4'd1;
    localparam logic [3:0] OpAnd = 4'd2;
    localparam logic [3:0] OpOr  = 4'd3;
    localparam logic [3:0] OpXor = 4'd4;
    localparam logic [3:0] OpSlt = 4'd5;
    localparam logic [3:0] OpSll = 4'd6;
    localparam logic [3:0] OpSrl = 4'd7;
    localparam logic [3:0] OpSra = 4'd8;
    localparam logic [3:0] OpMul = 4'd9;

    typedef enum logic [1:0] {StIdle, StMul, StDone} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             carry_q, carry_d;
    logic             zero_q, zero_d;
    logic             neg_q, neg_d;
    logic             ovf_q, ovf_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [SHW-1:0]   cnt_q, cnt_d;

    logic             accept;
    logic             is_sub;
    logic [WIDTH-1:0] b_add;
    logic [WIDTH:0]   sum;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] alu_res;
    logic             alu_c;
    logic             alu_v;
    logic [WIDTH-1:0] acc_next;

    always_comb begin
        InReady = 1'b0;
        if (!rst) begin
            unique case (state_q)
                StIdle:  InReady = 1'b1;
                StDone:  InReady = OutReady;
                default: InReady = 1'b0;
            endcase
        end
    end

    assign accept = InValid && InReady;

    // SUB shares the adder as A + ~B + 1, so carry-out means "no borrow".
    always_comb begin
        is_sub  = (ALUControl == OpSub);
        b_add   = is_sub ? ~B : B;
        sum     = {1'b0, A} + {1'b0, b_add} + {{WIDTH{1'b0}}, is_sub};
        shamt   = B[SHW-1:0];
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (ALUControl)
            OpAdd, OpSub: begin
                alu_res = sum[WIDTH-1:0];
                alu_c   = sum[WIDTH];
                alu_v   = (A[WIDTH-1] == b_add[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
            end
            OpAnd:   alu_res = A & B;
            OpOr:    alu_res = A | B;
            OpXor:   alu_res = A ^ B;
            OpSlt:   alu_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
            OpSll:   alu_res = A << shamt;
            OpSrl:   alu_res = A >> shamt;
            OpSra:   alu_res = $signed(A) >>> shamt;
            default: alu_res = '0;
        endcase
    end

    assign acc_next = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

    always_comb begin
        state_d     = state_q;
        result_d    = result_q;
        carry_d     = carry_q;
        zero_d      = zero_q;
        neg_d       = neg_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        if (accept) begin
            if (ALUControl == OpMul) begin
                state_d     = StMul;
                out_valid_d = 1'b0;
                mcand_d     = A;
                mplier_d    = B;
                acc_d       = '0;
                cnt_d       = '0;
            end else begin
                state_d     = StDone;
                out_valid_d = 1'b1;
                result_d    = alu_res;
                carry_d     = alu_c;
                ovf_d       = alu_v;
                zero_d      = (alu_res == '0);
                neg_d       = alu_res[WIDTH-1];
            end
        end else if (state_q == StDone && OutReady) begin
            state_d     = StIdle;
            out_valid_d = 1'b0;
        end else if (state_q == StMul) begin
            acc_d    = acc_next;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 1'b1;
            if (cnt_q == SHW'(WIDTH - 1)) begin
                state_d     = StDone;
                out_valid_d = 1'b1;
                cnt_d       = '0;
                result_d    = acc_next;
                carry_d     = 1'b0;
                ovf_d       = 1'b0;
                zero_d      = (acc_next == '0);
                neg_d       = acc_next[WIDTH-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            result_q    <= '0;
            carry_q     <= 1'b0;
            zero_q      <= 1'b0;
            neg_q       <= 1'b0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            result_q    <= result_d;
            carry_q     <= carry_d;
            zero_q      <= zero_d;
            neg_q       <= neg_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
        end
    end

    assign OutValid  = out_valid_q;
    assign ALUResult = result_q;
    assign Carry     = carry_q;
    assign Zero      = zero_q;
    assign Negative  = neg_q;
    assign Overflow  = ovf_q;

endmodule

// File: tb/tb_alu_pipelined.sv
// Bench for alu_pipelined (WIDTH=32): vector table plus scoreboard, with handshake,
// MUL latency, stall and reset-abort sequences.
module tb_alu_pipelined;

    typedef struct packed {
        logic [31:0] res;
        logic        c;
        logic        z;
        logic        n;
        logic        v;
    } exp_t;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        exp_t        e;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        InValid;
    logic        InReady;
    logic [31:0] A;
    logic [31:0] B;
    logic [3:0]  ALUControl;
    logic        OutValid;
    logic        OutReady;
    logic [31:0] ALUResult;
    logic        Carry;
    logic        Zero;
    logic        Negative;
    logic        Overflow;

    int   checks   = 0;
    int   failures = 0;
    exp_t sb[$];
    exp_t mon_e;
    vec_t vecs[17];

    alu_pipelined #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .InValid   (InValid),
        .InReady   (InReady),
        .A         (A),
        .B         (B),
        .ALUControl(ALUControl),
        .OutValid  (OutValid),
        .OutReady  (OutReady),
        .ALUResult (ALUResult),
        .Carry     (Carry),
        .Zero      (Zero),
        .Negative  (Negative),
        .Overflow  (Overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic vec_t mk(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] res, input logic c, input logic z,
                                input logic n, input logic v);
        vec_t t;
        t.op = op; t.a = a; t.b = b;
        t.e.res = res; t.e.c = c; t.e.z = z; t.e.n = n; t.e.v = v;
        return t;
    endfunction

    function automatic exp_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t m;
        longint sa, sb2, s;
        longint unsigned u;
        m = '0;
        sa = longint'($signed(a));
        sb2 = longint'($signed(b));
        case (op)
            4'd0: begin
                u = {32'h0, a} + {32'h0, b};
                m.res = u[31:0];
                m.c = u[32];
                s = sa + sb2;
                m.v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'd1: begin
                m.res = a - b;
                m.c = (a >= b);
                s = sa - sb2;
                m.v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'd2: m.res = a & b;
            4'd3: m.res = a | b;
            4'd4: m.res = a ^ b;
            4'd5: m.res = (sa < sb2) ? 32'd1 : 32'd0;
            4'd6: m.res = a << b[4:0];
            4'd7: m.res = a >> b[4:0];
            4'd8: begin
                s = sa >>> b[4:0];
                m.res = s[31:0];
            end
            4'd9: begin
                u = {32'h0, a} * {32'h0, b};
                m.res = u[31:0];
            end
            default: m.res = 32'h0;
        endcase
        m.z = (m.res == 32'h0);
        m.n = m.res[31];
        return m;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Holds the request until accepted; returns the number of cycles spent waiting.
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input exp_t e, input bit push, output int waited);
        InValid = 1'b1; ALUControl = op; A = a; B = b;
        waited = 0;
        while (!InReady && waited < 100) begin
            step();
            waited++;
        end
        if (!InReady) begin
            checks++;
            failures++;
            $display("FAIL issue_timeout op=%0d actual=InReady_low required=InReady_high", op);
            InValid = 1'b0;
        end else begin
            if (push) sb.push_back(e);
            step();
            InValid = 1'b0;
        end
    endtask

    always @(negedge clk) begin
        if (!rst && OutValid && OutReady) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_result actual=%h required=no_output", ALUResult);
            end else begin
                mon_e = sb.pop_front();
                check("result_flags", 64'({ALUResult, Carry, Zero, Negative, Overflow}),
                      64'(mon_e));
            end
        end
    end

    initial begin
        int   w;
        int   lat;
        int   bad;
        exp_t e;
        rst = 1'b1; InValid = 1'b0; OutReady = 1'b1; A = '0; B = '0; ALUControl = '0;

        vecs[0]  = mk(4'd0, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1, 1, 0, 0);
        vecs[1]  = mk(4'd1, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1, 0, 0, 1);
        vecs[2]  = mk(4'd5, 32'hFFFFFFFB, 32'h00000003, 32'h00000001, 0, 0, 0, 0);
        vecs[3]  = mk(4'd8, 32'hFFFFFFFB, 32'h00000021, 32'hFFFFFFFD, 0, 0, 1, 0);
        vecs[4]  = mk(4'd7, 32'hFFFFFFFB, 32'h00000021, 32'h7FFFFFFD, 0, 0, 0, 0);
        vecs[5]  = mk(4'd0, 32'h00000002, 32'h00000003, 32'h00000005, 0, 0, 0, 0);
        vecs[6]  = mk(4'd2, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 0, 0, 0, 0);
        vecs[7]  = mk(4'd3, 32'h00000000, 32'h00000000, 32'h00000000, 0, 1, 0, 0);
        vecs[8]  = mk(4'd4, 32'hAAAAAAAA, 32'h55555555, 32'hFFFFFFFF, 0, 0, 1, 0);
        vecs[9]  = mk(4'd6, 32'h00000001, 32'h0000001F, 32'h80000000, 0, 0, 1, 0);
        vecs[10] = mk(4'd1, 32'h00000005, 32'h00000005, 32'h00000000, 1, 1, 0, 0);
        vecs[11] = mk(4'd1, 32'h00000003, 32'h00000005, 32'hFFFFFFFE, 0, 0, 1, 0);
        vecs[12] = mk(4'd0, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 0, 0, 1, 1);
        vecs[13] = mk(4'd12, 32'h00000005, 32'h00000005, 32'h00000000, 0, 1, 0, 0);
        vecs[14] = mk(4'd9, 32'h0000FFFF, 32'h00010001, 32'hFFFFFFFF, 0, 0, 1, 0);
        vecs[15] = mk(4'd9, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 0, 0, 0, 0);
        vecs[16] = mk(4'd5, 32'h00000003, 32'hFFFFFFFB, 32'h00000000, 0, 1, 0, 0);

        repeat (3) step();
        check("rst_outvalid", 64'(OutValid), 64'd0);
        check("rst_outputs", 64'({ALUResult, Carry, Zero, Negative, Overflow}), 64'd0);
        check("rst_inready", 64'(InReady), 64'd0);
        rst = 1'b0;
        #1;
        check("inready_after_rst", 64'(InReady), 64'd1);

        foreach (vecs[i]) issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].e, 1'b1, w);

        // Back-to-back single-cycle ops, then a 5-cycle stall with a pending request.
        issue(4'd0, 32'd10, 32'd20, model(4'd0, 32'd10, 32'd20), 1'b1, w);
        issue(4'd4, 32'h0000F0F0, 32'h0000FF00, model(4'd4, 32'h0000F0F0, 32'h0000FF00), 1'b1, w);
        check("b2b_xor_no_wait", 64'(w), 64'd0);
        e = model(4'd5, 32'hFFFFFFFB, 32'h3);
        issue(4'd5, 32'hFFFFFFFB, 32'h00000003, e, 1'b1, w);
        check("b2b_slt_no_wait", 64'(w), 64'd0);
        OutReady = 1'b0;
        InValid = 1'b1; ALUControl = 4'd0; A = 32'd1; B = 32'd1;
        #1;
        for (int k = 0; k < 5; k++) begin
            check("stall_outvalid", 64'(OutValid), 64'd1);
            check("stall_inready", 64'(InReady), 64'd0);
            check("stall_hold", 64'({ALUResult, Carry, Zero, Negative, Overflow}), 64'(e));
            step();
        end
        InValid = 1'b0;
        OutReady = 1'b1;
        step();
        check("stall_no_accept", 64'(OutValid), 64'd0);

        // MUL latency and InReady low for the whole iteration.
        issue(4'd9, 32'h0000FFFF, 32'h00010001, model(4'd9, 32'h0000FFFF, 32'h00010001), 1'b1, w);
        lat = 0; bad = 0;
        while (!OutValid && lat < 40) begin
            if (InReady) bad++;
            step();
            lat++;
        end
        check("mul_latency", 64'(lat), 64'd32);
        check("mul_inready_low", 64'(bad), 64'd0);
        check("mul_value", 64'({ALUResult, Carry, Negative}), 64'({32'hFFFFFFFF, 1'b0, 1'b1}));
        step();

        // Reset on the 10th cycle of a MUL aborts it.
        issue(4'd9, 32'h12345678, 32'h9ABCDEF1, '0, 1'b0, w);
        repeat (9) step();
        rst = 1'b1;
        step();
        check("abort_outvalid", 64'(OutValid), 64'd0);
        check("abort_outputs", 64'({ALUResult, Carry, Zero, Negative, Overflow}), 64'd0);
        check("abort_inready_in_rst", 64'(InReady), 64'd0);
        rst = 1'b0;
        #1;
        check("abort_inready_after", 64'(InReady), 64'd1);
        bad = 0;
        for (int k = 0; k < 40; k++) begin
            if (OutValid) bad++;
            step();
        end
        check("abort_no_result", 64'(bad), 64'd0);
        issue(4'd0, 32'd2, 32'd3, mk(4'd0, 32'd2, 32'd3, 32'd5, 0, 0, 0, 0).e, 1'b1, w);
        step();

        // Reset wins over a simultaneous accept.
        InValid = 1'b1; ALUControl = 4'd0; A = 32'd7; B = 32'd8;
        rst = 1'b1;
        step();
        InValid = 1'b0;
        check("rst_priority", 64'(OutValid), 64'd0);
        rst = 1'b0;
        step();

        for (int k = 0; k < 30; k++) begin
            logic [3:0]  op;
            logic [31:0] a, b;
            op = 4'($urandom_range(0, 15));
            a = $urandom;
            b = $urandom;
            issue(op, a, b, model(op, a, b), 1'b1, w);
        end

        lat = 0;
        while (sb.size() != 0 && lat < 100) begin
            step();
            lat++;
        end
        check("scoreboard_drained", 64'(sb.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
